// File: rtl/alu_pipe.sv
// alu_pipe -- execute-stage integer ALU with a registered, handshaked result.
//
// Base RV32I/RV64I register-register ops complete in one cycle. Defining the
// macro ALU_PIPE_MULDIV_EN adds an iterative M-extension unit (shift-add
// multiply, restoring divide, XLEN steps per op). Without it, muldiv is
// ignored and the op runs as the base op named by function_select.
//
// Ports:
//   clk, reset (async, active-high), flush (sync abort, highest priority)
//   in_valid / in_ready       : operation handshake
//   input_a, input_b          : operands
//   function_select           : funct3
//   function_modifier         : funct7[5] (SUB / SRA / ANDN)
//   muldiv                    : M-extension op (funct7 == 1)
//   out_valid / out_ready     : result handshake
//   result                    : registered result
module alu_pipe #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] input_a,
  input  logic [XLEN-1:0] input_b,
  input  logic [2:0]      function_select,
  input  logic            function_modifier,
  input  logic            muldiv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  logic            load_en;      // output register may take a new value
  logic            accept;
  logic            base_accept;
  logic            md_load;      // M-unit result written this edge
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] md_res;
  logic [XLEN-1:0] result_reg;
  logic            out_valid_reg;

  assign load_en   = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

  always_comb begin
    base_res = '0;
    case (function_select)
      3'b000: begin
        if (function_modifier) base_res = input_a - input_b;
        else                   base_res = input_a + input_b;
      end
      3'b001: base_res = input_a << input_b[SHW-1:0];
      3'b010: base_res = {{(XLEN-1){1'b0}}, $signed(input_a) < $signed(input_b)};
      3'b011: base_res = {{(XLEN-1){1'b0}}, input_a < input_b};
      3'b100: base_res = input_a ^ input_b;
      3'b101: begin
        // keep the arithmetic shift in its own statement so the signed
        // operand is not turned unsigned by a mixed-sign expression
        if (function_modifier) base_res = $unsigned($signed(input_a) >>> input_b[SHW-1:0]);
        else                   base_res = input_a >> input_b[SHW-1:0];
      end
      3'b110: base_res = input_a | input_b;
      default: begin
        if (function_modifier) base_res = ~input_a & input_b;
        else                   base_res = input_a & input_b;
      end
    endcase
  end

  // Output register: flush drops the valid flag but leaves the data alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (base_accept) begin
      result_reg    <= base_res;
      out_valid_reg <= 1'b1;
    end else if (md_load) begin
      result_reg    <= md_res;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef ALU_PIPE_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [SHW-1:0]    count;
  // acc = {hi, lo}. Multiply: hi accumulates, lo holds the shifting multiplier.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   b_mag;
  logic [2:0]        op;
  logic              neg;        // final result must be negated
  logic              b_zero;
  logic              md_accept;
  logic              a_neg, b_neg, neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   hi, lo;

  assign in_ready    = (state == IDLE) && load_en;
  assign base_accept = accept && !muldiv;
  assign md_accept   = accept && muldiv;
  assign md_load     = (state == DONE) && load_en;

  // Operand signedness: mulh/div/rem treat both signed, mulhsu only A.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (function_select)
      3'b001, 3'b100, 3'b110: begin
        a_neg = input_a[XLEN-1];
        b_neg = input_b[XLEN-1];
      end
      3'b010:  a_neg = input_a[XLEN-1];
      default: ;
    endcase
  end

  // Remainder takes the dividend's sign; products and quotients the xor.
  assign neg_in   = (function_select == 3'b110) ? a_neg : (a_neg ^ b_neg);
  assign a_mag_in = a_neg ? -input_a : input_a;
  assign b_mag_in = b_neg ? -input_b : input_b;

  assign hi        = acc[2*XLEN-1:XLEN];
  assign lo        = acc[XLEN-1:0];
  assign mul_sum   = {1'b0, hi} + (acc[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
  assign div_shift = {hi, lo[XLEN-1]};

  always_comb begin
    acc_step = {mul_sum, lo[XLEN-1:1]};
    if (op[2]) begin
      if (div_shift >= {1'b0, b_mag}) acc_step = {div_shift[XLEN-1:0] - b_mag, lo[XLEN-2:0], 1'b1};
      else                            acc_step = {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (md_accept) state_next = BUSY;
        BUSY:    if (count == '0) state_next = DONE;
        DONE:    if (load_en) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      b_mag  <= '0;
      op     <= '0;
      neg    <= 1'b0;
      b_zero <= 1'b0;
      count  <= '0;
    end else if (md_accept) begin
      acc    <= {{XLEN{1'b0}}, a_mag_in};
      b_mag  <= b_mag_in;
      op     <= function_select;
      neg    <= neg_in;
      b_zero <= (input_b == '0);
      count  <= SHW'(XLEN - 1);
    end else if (state == BUSY) begin
      acc   <= acc_step;
      count <= count - SHW'(1);
    end
  end

  // Sign correction. Divide by zero yields an all-ones quotient regardless of
  // sign; the remainder naturally ends up equal to the dividend.
  assign prod_fix = neg ? -acc : acc;

  always_comb begin
    md_res = lo;
    case (op)
      3'b001, 3'b010, 3'b011: md_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_res = b_zero ? {XLEN{1'b1}} : (neg ? -lo : lo);
      3'b110, 3'b111:         md_res = neg ? -hi : hi;
      default:                md_res = lo;
    endcase
  end
`else
  logic unused_muldiv;
  assign unused_muldiv = muldiv;
  assign in_ready      = load_en;
  assign base_accept   = accept;
  assign md_load       = 1'b0;
  assign md_res        = '0;
`endif

endmodule
